// File: rtl/sm_run_ctrl.sv
// rtl/sm_run_ctrl.sv - run/halt/single-step controller gating the CPU clock enable
//
// Ports:
//   clk, rst             system clock, asynchronous active-high reset
//   cmd_valid/cmd_ready  command handshake; cmd_op 0 HALT, 1 RUN, 2 STEP, 3 SET_BP
//   cmd_arg              STEP count in [CNT_W-1:0], or SET_BP address (0 disables)
//   pc                   current PC word index from the CPU
//   cpu_en               CPU clock enable; one instruction per high cycle
//   halted, halt_reason  halted status; reason 0 reset, 1 HALT, 2 step done, 3 breakpoint
//   cyc_cnt              count of cpu_en-high cycles since reset, wrapping
module sm_run_ctrl #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [PC_W-1:0]  cmd_arg,
    input  logic [PC_W-1:0]  pc,
    output logic             cpu_en,
    output logic             halted,
    output logic [1:0]       halt_reason,
    output logic [CNT_W-1:0] cyc_cnt
);

    localparam logic [1:0] OP_HALT   = 2'd0;
    localparam logic [1:0] OP_RUN    = 2'd1;
    localparam logic [1:0] OP_STEP   = 2'd2;
    localparam logic [1:0] OP_SET_BP = 2'd3;

    localparam logic [1:0] RSN_HALT = 2'd1;
    localparam logic [1:0] RSN_STEP = 2'd2;
    localparam logic [1:0] RSN_BP   = 2'd3;

    typedef enum logic [1:0] {
        S_HALTED = 2'd0,
        S_RUN    = 2'd1,
        S_STEP   = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_ready;
    logic             r_halted;
    logic [1:0]       r_reason;
    logic [CNT_W-1:0] r_cyc;
    logic [CNT_W-1:0] r_cnt;
    logic [PC_W-1:0]  r_bp;
    logic             r_skip;

    logic w_accept;
    logic w_halt_cmd;
    logic w_bp_hit;
    logic w_active;
    logic w_cpu_en;

    assign w_accept   = cmd_valid & r_ready;
    assign w_halt_cmd = w_accept & (cmd_op == OP_HALT);
    // Breakpoint address 0 means disabled (PC 0 is the reset vector).
    // The skip flag lets the instruction sitting on the breakpoint execute once on resume.
    assign w_bp_hit   = (r_bp != '0) & (pc == r_bp) & ~r_skip;
    assign w_active   = (r_state == S_RUN) | (r_state == S_STEP);
    // A HALT accepted this cycle already suppresses the enable, so no extra instruction runs.
    assign w_cpu_en   = w_active & ~w_bp_hit & ~w_halt_cmd;

    assign cpu_en      = w_cpu_en;
    assign cmd_ready   = r_ready;
    assign halted      = r_halted;
    assign halt_reason = r_reason;
    assign cyc_cnt     = r_cyc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_HALTED;
            r_ready  <= 1'b0;
            r_halted <= 1'b1;
            r_reason <= 2'd0;
            r_cyc    <= '0;
            r_cnt    <= '0;
            r_bp     <= '0;
            r_skip   <= 1'b0;
        end else begin
            r_ready <= 1'b1;

            if (w_cpu_en) begin
                r_cyc  <= r_cyc + 1'b1;
                r_skip <= 1'b0;
            end

            if (w_accept && (cmd_op == OP_SET_BP)) begin
                r_bp <= cmd_arg;
            end

            case (r_state)
                S_HALTED: begin
                    if (w_accept) begin
                        if (cmd_op == OP_RUN) begin
                            r_state  <= S_RUN;
                            r_halted <= 1'b0;
                            r_skip   <= 1'b1;
                        end else if ((cmd_op == OP_STEP) && (cmd_arg[CNT_W-1:0] != '0)) begin
                            r_state  <= S_STEP;
                            r_halted <= 1'b0;
                            r_skip   <= 1'b1;
                            r_cnt    <= cmd_arg[CNT_W-1:0];
                        end else if (cmd_op == OP_HALT) begin
                            r_reason <= RSN_HALT;
                        end
                    end
                end
                S_RUN, S_STEP: begin
                    // Priority: HALT command, then breakpoint, then step completion.
                    if (w_halt_cmd) begin
                        r_state  <= S_HALTED;
                        r_halted <= 1'b1;
                        r_reason <= RSN_HALT;
                    end else if (w_bp_hit) begin
                        r_state  <= S_HALTED;
                        r_halted <= 1'b1;
                        r_reason <= RSN_BP;
                    end else if (r_state == S_STEP) begin
                        // Here cpu_en is high, so every STEP cycle consumes one count.
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CNT_W'(1)) begin
                            r_state  <= S_HALTED;
                            r_halted <= 1'b1;
                            r_reason <= RSN_STEP;
                        end
                    end
                end
                default: begin
                    r_state  <= S_HALTED;
                    r_halted <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm_run_ctrl.sv
// tb/tb_sm_run_ctrl.sv - directed self-checking bench for sm_run_ctrl
module tb_sm_run_ctrl;

    localparam int PC_W  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'd0;
    logic [PC_W-1:0]  cmd_arg = '0;
    logic [PC_W-1:0]  pc;
    logic             cpu_en;
    logic             halted;
    logic [1:0]       halt_reason;
    logic [CNT_W-1:0] cyc_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    sm_run_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_arg     (cmd_arg),
        .pc          (pc),
        .cpu_en      (cpu_en),
        .halted      (halted),
        .halt_reason (halt_reason),
        .cyc_cnt     (cyc_cnt)
    );

    always #5 clk = ~clk;

    // Minimal CPU: PC advances one word per enabled cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) pc <= '0;
        else if (cpu_en) pc <= pc + 1;
    end

    // Called just after a negedge; the command is accepted on the following posedge.
    task automatic send_cmd(input logic [1:0] op, input logic [PC_W-1:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL ready_after_rst_low: got %0b expected 0", cmd_ready); end
        @(negedge clk);
        n_tests++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_edge: got %0b expected 1", cmd_ready); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++;
        if (cpu_en !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_en: got %0b expected 0", cpu_en); end
        n_tests++;
        if (halted !== 1'b1) begin n_fail++; $display("FAIL reset_halted: got %0b expected 1", halted); end
        n_tests++;
        if (halt_reason !== 2'd0) begin n_fail++; $display("FAIL reset_reason: got %0d expected 0", halt_reason); end
        n_tests++;
        if (cyc_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cyc_cnt: got %0d expected 0", cyc_cnt); end
        do_reset();
    endtask

    task automatic test_step();
        int n;
        do_reset();
        send_cmd(2'd2, 32'd3);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (cpu_en === 1'b1) n++;
            @(negedge clk);
        end
        n_tests++;
        if (n != 3) begin n_fail++; $display("FAIL step3_en_cycles: got %0d expected 3", n); end
        n_tests++;
        if (pc !== 32'd3) begin n_fail++; $display("FAIL step3_pc: got %0d expected 3", pc); end
        n_tests++;
        if (halted !== 1'b1 || halt_reason !== 2'd2) begin n_fail++; $display("FAIL step3_halt: got halted %0b reason %0d expected 1 2", halted, halt_reason); end
        n_tests++;
        if (cyc_cnt !== 4'd3) begin n_fail++; $display("FAIL step3_cyc_cnt: got %0d expected 3", cyc_cnt); end
        send_cmd(2'd2, 32'd0);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (cpu_en === 1'b1) n++;
            @(negedge clk);
        end
        n_tests++;
        if (n != 0 || pc !== 32'd3 || halted !== 1'b1) begin n_fail++; $display("FAIL step0_noop: got en %0d pc %0d halted %0b expected 0 3 1", n, pc, halted); end
    endtask

    task automatic test_breakpoint();
        do_reset();
        send_cmd(2'd3, 32'd5);
        send_cmd(2'd1, 32'd0);
        for (int i = 0; i < 30 && halted !== 1'b1; i++) @(negedge clk);
        n_tests++;
        if (halted !== 1'b1 || halt_reason !== 2'd3) begin n_fail++; $display("FAIL bp_halt: got halted %0b reason %0d expected 1 3", halted, halt_reason); end
        n_tests++;
        if (pc !== 32'd5) begin n_fail++; $display("FAIL bp_pc: got %0d expected 5", pc); end
        n_tests++;
        if (cyc_cnt !== 4'd5) begin n_fail++; $display("FAIL bp_cyc_cnt: got %0d expected 5", cyc_cnt); end
        send_cmd(2'd1, 32'd0);
        n_tests++;
        if (cpu_en !== 1'b1) begin n_fail++; $display("FAIL bp_resume_en: got %0b expected 1", cpu_en); end
        repeat (3) @(negedge clk);
        n_tests++;
        if (pc !== 32'd8 || halted !== 1'b0) begin n_fail++; $display("FAIL bp_resume_run: got pc %0d halted %0b expected 8 0", pc, halted); end
        send_cmd(2'd0, 32'd0);
    endtask

    task automatic test_halt_cmd();
        do_reset();
        send_cmd(2'd1, 32'd0);
        repeat (10) @(negedge clk);
        send_cmd(2'd1, 32'd0);
        send_cmd(2'd2, 32'd2);
        n_tests++;
        if (halted !== 1'b0 || pc !== 32'd12) begin n_fail++; $display("FAIL run_extra_cmds: got halted %0b pc %0d expected 0 12", halted, pc); end
        repeat (4) @(negedge clk);
        n_tests++;
        if (halted !== 1'b0 || pc !== 32'd16) begin n_fail++; $display("FAIL run_step_ignored: got halted %0b pc %0d expected 0 16", halted, pc); end
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_arg = '0;
        #1;
        n_tests++;
        if (cpu_en !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL halt_accept_cycle: got en %0b ready %0b expected 0 1", cpu_en, cmd_ready); end
        @(negedge clk);
        cmd_valid = 1'b0;
        n_tests++;
        if (halted !== 1'b1 || halt_reason !== 2'd1 || pc !== 32'd16) begin n_fail++; $display("FAIL halt_cmd: got halted %0b reason %0d pc %0d expected 1 1 16", halted, halt_reason, pc); end
        n_tests++;
        if (cyc_cnt !== 4'd0) begin n_fail++; $display("FAIL halt_cyc_cnt: got %0d expected 0", cyc_cnt); end
    endtask

    task automatic test_step_bp_priority();
        do_reset();
        send_cmd(2'd3, 32'd4);
        send_cmd(2'd2, 32'd8);
        for (int i = 0; i < 30 && halted !== 1'b1; i++) @(negedge clk);
        n_tests++;
        if (halted !== 1'b1 || halt_reason !== 2'd3 || pc !== 32'd4) begin n_fail++; $display("FAIL step_bp: got halted %0b reason %0d pc %0d expected 1 3 4", halted, halt_reason, pc); end
        do_reset();
        send_cmd(2'd3, 32'd3);
        send_cmd(2'd1, 32'd0);
        repeat (3) @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_arg = '0;
        #1;
        n_tests++;
        if (pc !== 32'd3 || cpu_en !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL halt_bp_setup: got pc %0d en %0b halted %0b expected 3 0 0", pc, cpu_en, halted); end
        @(negedge clk);
        cmd_valid = 1'b0;
        n_tests++;
        if (halted !== 1'b1 || halt_reason !== 2'd1) begin n_fail++; $display("FAIL halt_over_bp: got halted %0b reason %0d expected 1 1", halted, halt_reason); end
    endtask

    task automatic test_reset_mid_run_and_wrap();
        do_reset();
        send_cmd(2'd1, 32'd0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if (cpu_en !== 1'b0 || halted !== 1'b1 || halt_reason !== 2'd0 || cyc_cnt !== 4'd0 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_run: got en %0b halted %0b reason %0d cyc %0d ready %0b expected 0 1 0 0 0", cpu_en, halted, halt_reason, cyc_cnt, cmd_ready);
        end
        do_reset();
        send_cmd(2'd1, 32'd0);
        repeat (15) @(negedge clk);
        n_tests++;
        if (cyc_cnt !== 4'd15) begin n_fail++; $display("FAIL wrap_pre: got %0d expected 15", cyc_cnt); end
        @(negedge clk);
        n_tests++;
        if (cyc_cnt !== 4'd0 || pc !== 32'd16) begin n_fail++; $display("FAIL wrap: got cyc %0d pc %0d expected 0 16", cyc_cnt, pc); end
        send_cmd(2'd0, 32'd0);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_step();
        test_breakpoint();
        test_halt_cmd();
        test_step_bp_priority();
        test_reset_mid_run_and_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
